// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity selectors and the
// parity helper. The receiver will reuse the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // XOR-reduce the (zero-extended) data word. Zero extension leaves the
    // result unchanged, so any width from 5 to 9 bits can be passed in.
    function automatic logic parity_calc(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte handshake between the upstream producer and the UART framer.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_i;
    logic                 valid_i;
    logic                 ready_o;

    modport master (output data_i, output valid_i, input ready_o);
    modport slave  (input  data_i, input  valid_i, output ready_o);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, 1 or 2
// stop bits. Every bit is paced by the external baud counter overflow, and
// the counter is held clear while idle and restarted on each consumed tick.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    uart_tx_frame_if.slave        bus,
    input  logic                  baud_of_i,
    output logic                  baud_clear_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int                 CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic               LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic               ODD_SEL   = (PARITY_ODD != 0);

    tx_state_t              r_state;
    logic [DATA_BITS-1:0]   r_shift;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_stop_cnt;
    logic                   r_parity;
    logic                   r_tx;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_done;

    tx_state_t              w_state_nxt;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic [CNT_W-1:0]       w_bit_cnt_nxt;
    logic                   w_stop_cnt_nxt;
    logic                   w_parity_nxt;
    logic                   w_tx_nxt;
    logic                   w_ready_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;
    logic                   w_accept;

    assign w_accept     = bus.valid_i && r_ready;
    assign baud_clear_o = (r_state == IDLE) || baud_of_i;
    assign tx_o         = r_tx;
    assign bus.ready_o  = r_ready;
    assign busy_o       = r_busy;
    assign done_o       = r_done;

    // State and registered outputs; reset aborts any frame and idles the line high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_parity   <= w_parity_nxt;
            r_tx       <= w_tx_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state decode; every state holds until a baud tick arrives.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = START;
            START:   if (baud_of_i) w_state_nxt = DATA;
            DATA:    if (baud_of_i && (r_bit_cnt == LAST_BIT))
                         w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (baud_of_i) w_state_nxt = STOP;
            STOP:    if (baud_of_i && (r_stop_cnt == LAST_STOP)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the line, handshake flags, shifter and counters.
    always_comb begin
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_parity_nxt   = r_parity;
        w_tx_nxt       = r_tx;
        w_ready_nxt    = r_ready;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_shift_nxt  = bus.data_i;
                    w_parity_nxt = parity_calc(9'(bus.data_i), ODD_SEL);
                    w_tx_nxt     = 1'b0;
                    w_ready_nxt  = 1'b0;
                    w_busy_nxt   = 1'b1;
                end
            end
            START: begin
                if (baud_of_i) begin
                    w_tx_nxt      = r_shift[0];
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (baud_of_i) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        // Stop counter cleared here too so frames without parity start clean.
                        w_tx_nxt       = (PARITY_EN != 0) ? r_parity : 1'b1;
                        w_stop_cnt_nxt = 1'b0;
                    end else begin
                        w_tx_nxt      = r_shift[0];
                        w_shift_nxt   = r_shift >> 1;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_of_i) begin
                    w_tx_nxt       = 1'b1;
                    w_stop_cnt_nxt = 1'b0;
                end
            end
            STOP: begin
                if (baud_of_i) begin
                    if (r_stop_cnt == LAST_STOP) begin
                        w_ready_nxt    = 1'b1;
                        w_busy_nxt     = 1'b0;
                        w_done_nxt     = 1'b1;
                        w_stop_cnt_nxt = 1'b0;
                    end else begin
                        w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four framer configurations (8N1, 8E1,
// 8O1, 8N2), each paced by its own 4-cycle baud model.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] data_d [4];
    logic [3:0] valid_d = 4'b0000;
    logic [3:0] tx_w, rdy_w, busy_w, done_w, clr_w, of_w;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    uart_tx_frame_if #(.DATA_BITS(8)) bus [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_bm
        logic [1:0] cnt = 2'd0;
        assign bus[g].data_i  = data_d[g];
        assign bus[g].valid_i = valid_d[g];
        assign rdy_w[g]       = bus[g].ready_o;
        assign of_w[g]        = (cnt == 2'd3);
        always @(posedge clk) begin
            if (clr_w[g]) cnt <= 2'd0;
            else          cnt <= cnt + 2'd1;
        end
    end

    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk_i(clk), .rst_i(rst_i), .bus(bus[0].slave), .baud_of_i(of_w[0]),
        .baud_clear_o(clr_w[0]), .tx_o(tx_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]));
    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk_i(clk), .rst_i(rst_i), .bus(bus[1].slave), .baud_of_i(of_w[1]),
        .baud_clear_o(clr_w[1]), .tx_o(tx_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]));
    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk_i(clk), .rst_i(rst_i), .bus(bus[2].slave), .baud_of_i(of_w[2]),
        .baud_clear_o(clr_w[2]), .tx_o(tx_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]));
    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
        .clk_i(clk), .rst_i(rst_i), .bus(bus[3].slave), .baud_of_i(of_w[3]),
        .baud_clear_o(clr_w[3]), .tx_o(tx_w[3]), .busy_o(busy_w[3]), .done_o(done_w[3]));

    // Called on a negedge: present a byte and return just after the accepting edge.
    task automatic start_frame(input int u, input logic [7:0] d, input bit keep_valid, output bit ok);
        data_d[u]  = d;
        valid_d[u] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rdy_w[u] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (!keep_valid || !ok) valid_d[u] = 1'b0;
    endtask

    // Observe n bit periods (4 cycles each) plus the cycle after the last stop bit.
    task automatic capture(input int u, input int n, output logic [15:0] bits, output int glitches,
                           output int rdy_hi, output int busy_lo, output int done_hi,
                           output logic [3:0] endf);
        bits = '0; glitches = 0; rdy_hi = 0; busy_lo = 0; done_hi = 0;
        for (int k = 0; k < 4 * n; k++) begin
            @(negedge clk);
            if (k % 4 == 0) bits[k/4] = tx_w[u];
            else if (tx_w[u] !== bits[k/4]) glitches++;
            if (rdy_w[u] !== 1'b0) rdy_hi++;
            if (busy_w[u] !== 1'b1) busy_lo++;
            if (done_w[u] !== 1'b0) done_hi++;
        end
        @(negedge clk);
        endf = {tx_w[u], rdy_w[u], busy_w[u], done_w[u]};
    endtask

    task automatic test_reset();
        for (int u = 0; u < 4; u++) data_d[u] = 8'h00;
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            n_total++;
            if ({tx_w[u], rdy_w[u], busy_w[u], done_w[u], clr_w[u]} !== 5'b11001)
                $display("FAIL reset_state[%0d]: got tx/rdy/busy/done/clr=%b expected 11001", u,
                         {tx_w[u], rdy_w[u], busy_w[u], done_w[u], clr_w[u]});
            else n_pass++;
        end
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({tx_w[0], rdy_w[0], busy_w[0], done_w[0], clr_w[0]} !== 5'b11001)
            $display("FAIL idle_after_reset: got %b expected 11001",
                     {tx_w[0], rdy_w[0], busy_w[0], done_w[0], clr_w[0]});
        else n_pass++;
    endtask

    task automatic test_8n1();
        logic [15:0] bits; int gl, rh, bl, dh; logic [3:0] endf; bit ok;
        start_frame(0, 8'hA5, 1'b0, ok);
        n_total++; if (!ok) $display("FAIL 8n1_accept: got timeout expected accept"); else n_pass++;
        capture(0, 10, bits, gl, rh, bl, dh, endf);
        // stop, A5 LSB first, start
        n_total++; if (bits[9:0] !== 10'b1101001010) $display("FAIL 8n1_bits: got %b expected 1101001010", bits[9:0]); else n_pass++;
        n_total++; if (gl !== 0) $display("FAIL 8n1_bit_len: got %0d unstable cycles expected 0", gl); else n_pass++;
        n_total++; if (rh !== 0 || bl !== 0) $display("FAIL 8n1_ready_busy: got rdy_hi=%0d busy_lo=%0d expected 0 0", rh, bl); else n_pass++;
        n_total++; if (dh !== 0) $display("FAIL 8n1_early_done: got %0d expected 0", dh); else n_pass++;
        n_total++; if (endf !== 4'b1101) $display("FAIL 8n1_end: got tx/rdy/busy/done=%b expected 1101", endf); else n_pass++;
        @(negedge clk);
        n_total++; if (done_w[0] !== 1'b0) $display("FAIL 8n1_done_pulse: got %b expected 0", done_w[0]); else n_pass++;
    endtask

    task automatic test_parity();
        logic [15:0] bits; int gl, rh, bl, dh; logic [3:0] endf; bit ok;
        start_frame(1, 8'h07, 1'b0, ok);
        n_total++; if (!ok) $display("FAIL even_accept: got timeout expected accept"); else n_pass++;
        capture(1, 11, bits, gl, rh, bl, dh, endf);
        n_total++; if (bits[10:0] !== 11'b11000001110) $display("FAIL even_bits: got %b expected 11000001110", bits[10:0]); else n_pass++;
        n_total++; if (gl !== 0 || rh !== 0 || dh !== 0) $display("FAIL even_frame: got glitch=%0d rdy_hi=%0d done=%0d expected 0 0 0", gl, rh, dh); else n_pass++;
        n_total++; if (endf !== 4'b1101) $display("FAIL even_end: got %b expected 1101", endf); else n_pass++;
        start_frame(2, 8'h07, 1'b0, ok);
        n_total++; if (!ok) $display("FAIL odd_accept: got timeout expected accept"); else n_pass++;
        capture(2, 11, bits, gl, rh, bl, dh, endf);
        n_total++; if (bits[10:0] !== 11'b10000001110) $display("FAIL odd_bits: got %b expected 10000001110", bits[10:0]); else n_pass++;
        n_total++; if (gl !== 0 || rh !== 0 || dh !== 0) $display("FAIL odd_frame: got glitch=%0d rdy_hi=%0d done=%0d expected 0 0 0", gl, rh, dh); else n_pass++;
        n_total++; if (endf !== 4'b1101) $display("FAIL odd_end: got %b expected 1101", endf); else n_pass++;
    endtask

    task automatic test_two_stop();
        logic [15:0] bits; int gl, rh, bl, dh; logic [3:0] endf; bit ok;
        start_frame(3, 8'hFF, 1'b0, ok);
        n_total++; if (!ok) $display("FAIL 8n2_accept: got timeout expected accept"); else n_pass++;
        capture(3, 11, bits, gl, rh, bl, dh, endf);
        n_total++; if (bits[10:0] !== 11'b11111111110) $display("FAIL 8n2_bits: got %b expected 11111111110", bits[10:0]); else n_pass++;
        n_total++; if (gl !== 0 || rh !== 0 || bl !== 0) $display("FAIL 8n2_frame: got glitch=%0d rdy_hi=%0d busy_lo=%0d expected 0 0 0", gl, rh, bl); else n_pass++;
        n_total++; if (dh !== 0) $display("FAIL 8n2_early_done: got %0d expected 0", dh); else n_pass++;
        n_total++; if (endf !== 4'b1101) $display("FAIL 8n2_end: got %b expected 1101", endf); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits; int gl, rh, bl, dh; logic [3:0] endf; bit ok;
        start_frame(0, 8'h3C, 1'b1, ok);
        data_d[0] = 8'hC3;
        n_total++; if (!ok) $display("FAIL b2b_accept: got timeout expected accept"); else n_pass++;
        capture(0, 10, bits, gl, rh, bl, dh, endf);
        n_total++; if (bits[9:0] !== 10'b1001111000) $display("FAIL b2b_first_bits: got %b expected 1001111000", bits[9:0]); else n_pass++;
        n_total++; if (gl !== 0 || rh !== 0) $display("FAIL b2b_first_frame: got glitch=%0d rdy_hi=%0d expected 0 0", gl, rh); else n_pass++;
        n_total++; if (endf !== 4'b1101) $display("FAIL b2b_gap: got %b expected 1101", endf); else n_pass++;
        @(posedge clk);
        #1;
        valid_d[0] = 1'b0;
        capture(0, 10, bits, gl, rh, bl, dh, endf);
        n_total++; if (bits[9:0] !== 10'b1110000110) $display("FAIL b2b_second_bits: got %b expected 1110000110", bits[9:0]); else n_pass++;
        n_total++; if (gl !== 0 || rh !== 0 || bl !== 0) $display("FAIL b2b_second_frame: got glitch=%0d rdy_hi=%0d busy_lo=%0d expected 0 0 0", gl, rh, bl); else n_pass++;
        n_total++; if (endf !== 4'b1101) $display("FAIL b2b_second_end: got %b expected 1101", endf); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [15:0] bits; int gl, rh, bl, dh; logic [3:0] endf; bit ok;
        start_frame(0, 8'h55, 1'b0, ok);
        n_total++; if (!ok) $display("FAIL rst_accept: got timeout expected accept"); else n_pass++;
        repeat (17) @(negedge clk);
        // Now inside data bit 3 of 0x55, which is a zero on the line.
        n_total++; if ({tx_w[0], busy_w[0]} !== 2'b01) $display("FAIL rst_pre: got tx/busy=%b expected 01", {tx_w[0], busy_w[0]}); else n_pass++;
        rst_i = 1'b1;
        #1;
        n_total++; if ({tx_w[0], rdy_w[0], busy_w[0], done_w[0]} !== 4'b1100) $display("FAIL rst_async: got %b expected 1100", {tx_w[0], rdy_w[0], busy_w[0], done_w[0]}); else n_pass++;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        start_frame(0, 8'h0F, 1'b0, ok);
        n_total++; if (!ok) $display("FAIL rst_reaccept: got timeout expected accept"); else n_pass++;
        capture(0, 10, bits, gl, rh, bl, dh, endf);
        n_total++; if (bits[9:0] !== 10'b1000011110) $display("FAIL rst_next_bits: got %b expected 1000011110", bits[9:0]); else n_pass++;
        n_total++; if (gl !== 0 || rh !== 0 || dh !== 0) $display("FAIL rst_next_frame: got glitch=%0d rdy_hi=%0d done=%0d expected 0 0 0", gl, rh, dh); else n_pass++;
        n_total++; if (endf !== 4'b1101) $display("FAIL rst_next_end: got %b expected 1101", endf); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
